// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencer: PC control codes, FSM state codes
// and default widths.
package fetch_ctrl_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int CTRL_W_DEF = 2;
    localparam int PERF_W_DEF = 32;

    // Codes understood by the PC register.
    typedef enum logic [1:0] {
        CTRL_STATE_DEFAULT = 2'b00,
        CTRL_STATE_BLOCK   = 2'b01,
        CTRL_STATE_BRANCH  = 2'b10
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FETCH_CTRL_RUN  = 2'b00,
        FETCH_CTRL_WAIT = 2'b01,
        FETCH_CTRL_KILL = 2'b10
    } fetch_state_e;

    function automatic logic is_redirect(input logic trap, input logic branch);
        return trap | branch;
    endfunction

endpackage

// File: rtl/fetch_ctrl_perf.sv
// Saturating event counter for the fetch sequencer's performance monitors.
// Holds at all-ones instead of wrapping; clears on synchronous reset.
module fetch_ctrl_perf #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    // NOTE: state is only ever written with <= inside always_ff so every
    // register samples its inputs at the same edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {PERF_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch front-end sequencer: arbitrates trap/branch redirects against stall and
// tracks the single outstanding icache fetch. Optional FETCH_CTRL_PERF_EN adds counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_target_i,
    input  logic              branch_req_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              stall_req_i,
    input  logic              icache_req_valid_i,
    input  logic              icache_req_ready_i,
    input  logic              icache_resp_valid_i,
    output logic [CTRL_W-1:0] ctrl_signal_o,
    output logic [ADDR_W-1:0] pc_new_o,
    output logic              flush_o,
    output logic              resp_discard_o,
    output logic [PERF_W-1:0] perf_stall_o,
    output logic [PERF_W-1:0] perf_redirect_o,
    output logic [PERF_W-1:0] perf_discard_o
);

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] pend_tgt, pend_tgt_next;
    logic              pend_trap, pend_trap_next;

    ctrl_state_e       ctrl;
    logic [ADDR_W-1:0] pc_new;
    logic              flush, discard;

    logic              accept, redir, resp;
    logic [ADDR_W-1:0] tgt;

    assign accept = icache_req_valid_i & icache_req_ready_i;
    assign redir  = is_redirect(trap_req_i, branch_req_i);
    assign resp   = icache_resp_valid_i;
    assign tgt    = trap_req_i ? trap_target_i : branch_target_i;

    // NOTE: every signal written here gets a default first so no path through
    // the case/if tree leaves it unassigned and infers a latch.
    always_comb begin
        state_next     = state;
        pend_tgt_next  = pend_tgt;
        pend_trap_next = pend_trap;
        ctrl           = CTRL_STATE_BLOCK;
        pc_new         = '0;
        flush          = 1'b0;
        discard        = 1'b0;

        if (!rst) begin
            case (state)
                FETCH_CTRL_RUN: begin
                    // A response with no fetch in flight is left over from before a reset.
                    if (resp && !accept) discard = 1'b1;

                    if (redir) begin
                        flush = 1'b1;
                        if (accept && !resp) begin
                            // Fetch just launched on the dead path: hold PC until it returns.
                            pend_tgt_next  = tgt;
                            pend_trap_next = trap_req_i;
                            state_next     = FETCH_CTRL_KILL;
                        end else begin
                            ctrl   = CTRL_STATE_BRANCH;
                            pc_new = tgt;
                            if (accept) discard = 1'b1;
                        end
                    end else if (accept && !resp) begin
                        state_next = FETCH_CTRL_WAIT;
                    end else if (!stall_req_i) begin
                        ctrl = CTRL_STATE_DEFAULT;
                    end
                end

                FETCH_CTRL_WAIT: begin
                    if (resp) begin
                        state_next = FETCH_CTRL_RUN;
                        if (redir) begin
                            ctrl    = CTRL_STATE_BRANCH;
                            pc_new  = tgt;
                            flush   = 1'b1;
                            discard = 1'b1;
                        end else if (!stall_req_i) begin
                            ctrl = CTRL_STATE_DEFAULT;
                        end
                    end else if (redir) begin
                        flush          = 1'b1;
                        pend_tgt_next  = tgt;
                        pend_trap_next = trap_req_i;
                        state_next     = FETCH_CTRL_KILL;
                    end
                end

                FETCH_CTRL_KILL: begin
                    // Only a trap can displace the pending redirect; branches are stale here.
                    if (trap_req_i) begin
                        pend_tgt_next  = trap_target_i;
                        pend_trap_next = 1'b1;
                    end
                    if (resp) begin
                        ctrl       = CTRL_STATE_BRANCH;
                        pc_new     = trap_req_i ? trap_target_i : pend_tgt;
                        discard    = 1'b1;
                        state_next = FETCH_CTRL_RUN;
                    end
                end

                default: state_next = FETCH_CTRL_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH_CTRL_RUN;
            pend_tgt  <= '0;
            pend_trap <= 1'b0;
        end else begin
            state     <= state_next;
            pend_tgt  <= pend_tgt_next;
            pend_trap <= pend_trap_next;
        end
    end

    // A trap-sourced pending target must survive a quiet KILL cycle untouched.
    assert property (@(posedge clk) disable iff (rst)
        (state == FETCH_CTRL_KILL && pend_trap && !trap_req_i && !resp)
        |=> (pend_trap && pend_tgt == $past(pend_tgt)));

    assign ctrl_signal_o  = CTRL_W'(ctrl);
    assign pc_new_o       = pc_new;
    assign flush_o        = flush;
    assign resp_discard_o = discard;

`ifdef FETCH_CTRL_PERF_EN
    fetch_ctrl_perf #(.PERF_W(PERF_W)) u_perf_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl == CTRL_STATE_BLOCK),
        .count (perf_stall_o)
    );

    fetch_ctrl_perf #(.PERF_W(PERF_W)) u_perf_redirect (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl == CTRL_STATE_BRANCH),
        .count (perf_redirect_o)
    );

    fetch_ctrl_perf #(.PERF_W(PERF_W)) u_perf_discard (
        .clk   (clk),
        .rst   (rst),
        .inc   (discard),
        .count (perf_discard_o)
    );
`else
    assign perf_stall_o    = '0;
    assign perf_redirect_o = '0;
    assign perf_discard_o  = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch/redirect rules.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam ctrl_state_e DEF = CTRL_STATE_DEFAULT;
    localparam ctrl_state_e BLK = CTRL_STATE_BLOCK;
    localparam ctrl_state_e BRN = CTRL_STATE_BRANCH;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_req, branch_req, stall_req;
    logic [63:0] trap_target, branch_target;
    logic        req_valid, req_ready, resp_valid;

    logic [1:0]  ctrl;
    logic [63:0] pc_new;
    logic        flush, discard;
    logic [31:0] perf_stall, perf_redirect, perf_discard;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .trap_req_i          (trap_req),
        .trap_target_i       (trap_target),
        .branch_req_i        (branch_req),
        .branch_target_i     (branch_target),
        .stall_req_i         (stall_req),
        .icache_req_valid_i  (req_valid),
        .icache_req_ready_i  (req_ready),
        .icache_resp_valid_i (resp_valid),
        .ctrl_signal_o       (ctrl),
        .pc_new_o            (pc_new),
        .flush_o             (flush),
        .resp_discard_o      (discard),
        .perf_stall_o        (perf_stall),
        .perf_redirect_o     (perf_redirect),
        .perf_discard_o      (perf_discard)
    );

`ifdef FETCH_CTRL_PERF_EN
    logic [1:0]  n_ctrl;
    logic [63:0] n_pc;
    logic        n_flush, n_discard;
    logic [3:0]  n_stall, n_redirect, n_disc;

    fetch_ctrl #(.PERF_W(4)) dut_narrow (
        .clk                 (clk),
        .rst                 (rst),
        .trap_req_i          (trap_req),
        .trap_target_i       (trap_target),
        .branch_req_i        (branch_req),
        .branch_target_i     (branch_target),
        .stall_req_i         (stall_req),
        .icache_req_valid_i  (req_valid),
        .icache_req_ready_i  (req_ready),
        .icache_resp_valid_i (resp_valid),
        .ctrl_signal_o       (n_ctrl),
        .pc_new_o            (n_pc),
        .flush_o             (n_flush),
        .resp_discard_o      (n_discard),
        .perf_stall_o        (n_stall),
        .perf_redirect_o     (n_redirect),
        .perf_discard_o      (n_disc)
    );
`endif

    // Reference model: one fetch may be in flight, and a redirect that arrives
    // while it is in flight is parked until its response comes back.
    typedef struct packed {
        bit          outstanding;
        bit          pending;
        logic [63:0] pend_addr;
        int          n_block;
        int          n_branch;
        int          n_discard;
    } model_t;

    typedef struct packed {
        ctrl_state_e ctrl;
        logic [63:0] pc;
        bit          flush;
        bit          discard;
    } exp_t;

    model_t m = '0;

    function automatic void model_step(input model_t cur, output exp_t e, output model_t nxt);
        logic        acc, redir;
        logic [63:0] tgt;
        acc   = req_valid & req_ready;
        redir = trap_req | branch_req;
        tgt   = trap_req ? trap_target : branch_target;
        nxt   = cur;
        e     = '{ctrl: BLK, pc: 64'h0, flush: 1'b0, discard: 1'b0};
        if (rst) begin
            nxt = '0;
            return;
        end
        if (!cur.outstanding) begin
            e.discard = resp_valid & ~acc;
            if (redir) begin
                e.flush = 1'b1;
                if (acc && !resp_valid) begin
                    nxt.outstanding = 1'b1;
                    nxt.pending     = 1'b1;
                    nxt.pend_addr   = tgt;
                end else begin
                    e.ctrl = BRN;
                    e.pc   = tgt;
                    if (acc) e.discard = 1'b1;
                end
            end else if (acc && !resp_valid) begin
                nxt.outstanding = 1'b1;
            end else begin
                e.ctrl = stall_req ? BLK : DEF;
            end
        end else if (!cur.pending) begin
            if (resp_valid) begin
                nxt.outstanding = 1'b0;
                if (redir) begin
                    e = '{ctrl: BRN, pc: tgt, flush: 1'b1, discard: 1'b1};
                end else begin
                    e.ctrl = stall_req ? BLK : DEF;
                end
            end else if (redir) begin
                e.flush       = 1'b1;
                nxt.pending   = 1'b1;
                nxt.pend_addr = tgt;
            end
        end else begin
            if (trap_req) nxt.pend_addr = trap_target;
            if (resp_valid) begin
                e.ctrl          = BRN;
                e.pc            = nxt.pend_addr;
                e.discard       = 1'b1;
                nxt.outstanding = 1'b0;
                nxt.pending     = 1'b0;
            end
        end
        if (e.ctrl == BLK) nxt.n_block++;
        if (e.ctrl == BRN) nxt.n_branch++;
        if (e.discard)     nxt.n_discard++;
    endfunction

    always @(posedge clk) begin
        exp_t   e_tick;
        model_t m_next;
        model_step(m, e_tick, m_next);
        m <= m_next;
    end

    typedef struct packed {
        bit          acc;
        bit          resp;
        bit          br;
        bit          tr;
        bit          st;
        logic [63:0] tgt;
        ctrl_state_e ctrl;
        bit          flush;
        bit          disc;
        logic [63:0] pc;
    } step_t;

    task automatic idle_inputs();
        trap_req = 0; branch_req = 0; stall_req = 0;
        trap_target = '0; branch_target = '0;
        req_valid = 0; req_ready = 0; resp_valid = 0;
    endtask

    task automatic apply_step(input step_t s);
        @(negedge clk);
        req_valid = s.acc; req_ready = s.acc; resp_valid = s.resp;
        branch_req = s.br; trap_req = s.tr; stall_req = s.st;
        branch_target = s.tgt; trap_target = s.tgt;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = (i < 3);
            req_valid = 1; req_ready = 1; resp_valid = 1;
            #1;
            total++;
            if (rst && (ctrl !== BLK || pc_new !== 64'h0 || flush !== 1'b0 || discard !== 1'b0)) begin
                $display("FAIL reset cycle %0d: ctrl=%0d pc=%h flush=%0b discard=%0b, expected ctrl=%0d pc=0 flush=0 discard=0",
                         i, ctrl, pc_new, flush, discard, BLK);
            end else if (!rst && (ctrl !== DEF || flush !== 1'b0 || discard !== 1'b0)) begin
                $display("FAIL reset_release: ctrl=%0d flush=%0b discard=%0b, expected ctrl=%0d flush=0 discard=0",
                         ctrl, flush, discard, DEF);
            end else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_wait_resp();
        step_t tbl [0:5] = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, BLK, 1'b0, 1'b0, 64'h0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, BLK, 1'b0, 1'b0, 64'h0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, BLK, 1'b0, 1'b0, 64'h0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, BLK, 1'b0, 1'b0, 64'h0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, DEF, 1'b0, 1'b0, 64'h0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, DEF, 1'b0, 1'b0, 64'h0}};
        for (int i = 0; i < 6; i++) begin
            apply_step(tbl[i]);
            total++;
            if (ctrl !== tbl[i].ctrl || flush !== tbl[i].flush || discard !== tbl[i].disc) begin
                $display("FAIL wait_resp step %0d: ctrl=%0d flush=%0b discard=%0b, expected ctrl=%0d flush=%0b discard=%0b",
                         i, ctrl, flush, discard, tbl[i].ctrl, tbl[i].flush, tbl[i].disc);
            end else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_branch_in_wait();
        step_t tbl [0:4] = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,        BLK, 1'b0, 1'b0, 64'h0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h80000040, BLK, 1'b1, 1'b0, 64'h0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,        BLK, 1'b0, 1'b0, 64'h0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,        BRN, 1'b0, 1'b1, 64'h80000040},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,        DEF, 1'b0, 1'b0, 64'h0}};
        for (int i = 0; i < 5; i++) begin
            apply_step(tbl[i]);
            total++;
            if (ctrl !== tbl[i].ctrl || flush !== tbl[i].flush || discard !== tbl[i].disc ||
                (tbl[i].ctrl == BRN && pc_new !== tbl[i].pc)) begin
                $display("FAIL branch_in_wait step %0d: ctrl=%0d flush=%0b discard=%0b pc=%h, expected ctrl=%0d flush=%0b discard=%0b pc=%h",
                         i, ctrl, flush, discard, pc_new, tbl[i].ctrl, tbl[i].flush, tbl[i].disc, tbl[i].pc);
            end else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_trap_in_kill();
        step_t tbl [0:5] = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,        BLK, 1'b0, 1'b0, 64'h0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h80000040, BLK, 1'b1, 1'b0, 64'h0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h80000100, BLK, 1'b0, 1'b0, 64'h0},
            '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h12345678, BLK, 1'b0, 1'b0, 64'h0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h12345678, BRN, 1'b0, 1'b1, 64'h80000100},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,        DEF, 1'b0, 1'b0, 64'h0}};
        for (int i = 0; i < 6; i++) begin
            apply_step(tbl[i]);
            total++;
            if (ctrl !== tbl[i].ctrl || flush !== tbl[i].flush || discard !== tbl[i].disc ||
                (tbl[i].ctrl == BRN && pc_new !== tbl[i].pc)) begin
                $display("FAIL trap_in_kill step %0d: ctrl=%0d flush=%0b discard=%0b pc=%h, expected ctrl=%0d flush=%0b discard=%0b pc=%h",
                         i, ctrl, flush, discard, pc_new, tbl[i].ctrl, tbl[i].flush, tbl[i].disc, tbl[i].pc);
            end else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_stall_vs_branch();
        step_t tbl [0:3] = '{
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h00001234, BRN, 1'b1, 1'b0, 64'h00001234},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0,        BLK, 1'b0, 1'b0, 64'h0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,        DEF, 1'b0, 1'b1, 64'h0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h00000777, BRN, 1'b1, 1'b1, 64'h00000777}};
        for (int i = 0; i < 4; i++) begin
            apply_step(tbl[i]);
            total++;
            if (ctrl !== tbl[i].ctrl || flush !== tbl[i].flush || discard !== tbl[i].disc ||
                (tbl[i].ctrl == BRN && pc_new !== tbl[i].pc)) begin
                $display("FAIL stall_vs_branch step %0d: ctrl=%0d flush=%0b discard=%0b pc=%h, expected ctrl=%0d flush=%0b discard=%0b pc=%h",
                         i, ctrl, flush, discard, pc_new, tbl[i].ctrl, tbl[i].flush, tbl[i].disc, tbl[i].pc);
            end else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_random();
        exp_t   e;
        model_t n;
        int     errs = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 149) == 0);
            trap_req      = ($urandom_range(0, 15) == 0);
            branch_req    = ($urandom_range(0, 5) == 0);
            stall_req     = ($urandom_range(0, 3) == 0);
            req_valid     = ($urandom_range(0, 3) != 0);
            req_ready     = $urandom_range(0, 1);
            resp_valid    = ($urandom_range(0, 2) == 0);
            trap_target   = {$urandom, $urandom};
            branch_target = {$urandom, $urandom};
            #1;
            model_step(m, e, n);
            total++;
            if (ctrl !== e.ctrl || flush !== e.flush || discard !== e.discard ||
                ((e.ctrl == BRN || rst) && pc_new !== e.pc)) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random cycle %0d: ctrl=%0d flush=%0b discard=%0b pc=%h, expected ctrl=%0d flush=%0b discard=%0b pc=%h",
                             cyc, ctrl, flush, discard, pc_new, e.ctrl, e.flush, e.discard, e.pc);
            end else passed++;
        end
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
`ifdef FETCH_CTRL_PERF_EN
        total++;
        if (perf_stall !== 32'(m.n_block) || perf_redirect !== 32'(m.n_branch) || perf_discard !== 32'(m.n_discard)) begin
            $display("FAIL random_perf: stall=%0d redirect=%0d discard=%0d, expected %0d/%0d/%0d",
                     perf_stall, perf_redirect, perf_discard, m.n_block, m.n_branch, m.n_discard);
        end else passed++;
`endif
    endtask

    task automatic test_perf();
        step_t s;
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, DEF, 1'b0, 1'b0, 64'h0};
        apply_step(s);
        s.st = 1'b1;
        for (int i = 0; i < 10; i++) apply_step(s);
        s.st = 1'b0; s.br = 1'b1; s.tgt = 64'h4000;
        for (int i = 0; i < 2; i++) apply_step(s);
        s.br = 1'b0; s.resp = 1'b1;
        apply_step(s);
        s.resp = 1'b0;
        apply_step(s);
        total++;
`ifdef FETCH_CTRL_PERF_EN
        if (perf_stall !== 32'd10 || perf_redirect !== 32'd2 || perf_discard !== 32'd1) begin
`else
        if (perf_stall !== 32'd0 || perf_redirect !== 32'd0 || perf_discard !== 32'd0) begin
`endif
            $display("FAIL perf_counts: stall=%0d redirect=%0d discard=%0d", perf_stall, perf_redirect, perf_discard);
        end else passed++;

        s.st = 1'b1;
        for (int i = 0; i < 20; i++) apply_step(s);
        s.st = 1'b0;
        apply_step(s);
        total++;
`ifdef FETCH_CTRL_PERF_EN
        if (perf_stall !== 32'd30 || n_stall !== 4'd15 || n_redirect !== 4'd2 || n_disc !== 4'd1) begin
            $display("FAIL perf_saturate: stall32=%0d stall4=%0d redirect4=%0d discard4=%0d, expected 30/15/2/1",
                     perf_stall, n_stall, n_redirect, n_disc);
`else
        if (perf_stall !== 32'd0) begin
            $display("FAIL perf_tied: stall=%0d, expected 0", perf_stall);
`endif
        end else passed++;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_wait_resp();
        test_branch_in_wait();
        test_trap_in_kill();
        test_stall_vs_branch();
        test_random();
        test_perf();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
